// File: rtl/bus_read_arbiter.sv
// ============================================================================
// Module      : bus_read_arbiter
// Description : Arbitrates instruction and data read requesters onto one
//               memory read port. Optional macro: ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module bus_read_arbiter #(
    parameter int BUS_WIDTH = `BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ir_addr_valid,
    output logic                 ir_addr_ready,
    input  logic [BUS_WIDTH-1:0] ir_addr,
    output logic                 ir_data_valid,
    input  logic                 ir_data_ready,
    output logic [BUS_WIDTH-1:0] ir_data,

    input  logic                 dr_addr_valid,
    output logic                 dr_addr_ready,
    input  logic [BUS_WIDTH-1:0] dr_addr,
    output logic                 dr_data_valid,
    input  logic                 dr_data_ready,
    output logic [BUS_WIDTH-1:0] dr_data,

    output logic                 m_addr_valid,
    input  logic                 m_addr_ready,
    output logic [BUS_WIDTH-1:0] m_addr,
    input  logic                 m_data_valid,
    output logic                 m_data_ready,
    input  logic [BUS_WIDTH-1:0] m_data,

    output logic [1:0]           gnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [1:0] c_GNT_NONE  = 2'b00;
    localparam logic [1:0] c_GNT_INSTR = 2'b01;
    localparam logic [1:0] c_GNT_DATA  = 2'b10;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] pick;

    logic                 in_addr;
    logic                 in_data;
    logic                 sel_addr_valid;
    logic [BUS_WIDTH-1:0] sel_addr;
    logic                 sel_data_ready;

    assign in_addr = (state_q == S_ADDR);
    assign in_data = (state_q == S_DATA);

    // Selected requester's signals; zero when nothing is granted.
    assign sel_addr_valid = (gnt_q[0] & ir_addr_valid) | (gnt_q[1] & dr_addr_valid);
    assign sel_addr       = gnt_q[0] ? ir_addr : (gnt_q[1] ? dr_addr : '0);
    assign sel_data_ready = (gnt_q[0] & ir_data_ready) | (gnt_q[1] & dr_data_ready);

`ifdef ARB_ROUND_ROBIN_EN
    // last_q = 1 means the data requester was served last.
    logic last_q, last_d;

    assign last_d = (in_data && m_data_valid && sel_data_ready) ? gnt_q[1] : last_q;

    always_comb begin
        pick = c_GNT_NONE;
        if (ir_addr_valid && dr_addr_valid) begin
            pick = last_q ? c_GNT_INSTR : c_GNT_DATA;
        end else if (ir_addr_valid) begin
            pick = c_GNT_INSTR;
        end else if (dr_addr_valid) begin
            pick = c_GNT_DATA;
        end
    end
`else
    always_comb begin
        pick = c_GNT_NONE;
        if (ir_addr_valid) begin
            pick = c_GNT_INSTR;
        end else if (dr_addr_valid) begin
            pick = c_GNT_DATA;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (ir_addr_valid || dr_addr_valid) begin
                    state_d = S_ADDR;
                    gnt_d   = pick;
                end
            end
            S_ADDR: begin
                // A withdrawn request abandons the grant without touching memory.
                if (!sel_addr_valid) begin
                    state_d = S_IDLE;
                    gnt_d   = c_GNT_NONE;
                end else if (m_addr_ready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (m_data_valid && sel_data_ready) begin
                    state_d = S_IDLE;
                    gnt_d   = c_GNT_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = c_GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= c_GNT_NONE;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt = gnt_q;

    assign m_addr_valid  = in_addr & sel_addr_valid;
    assign m_addr        = in_addr ? sel_addr : '0;
    assign ir_addr_ready = in_addr & gnt_q[0] & m_addr_ready;
    assign dr_addr_ready = in_addr & gnt_q[1] & m_addr_ready;

    assign m_data_ready  = in_data & sel_data_ready;
    assign ir_data_valid = in_data & gnt_q[0] & m_data_valid;
    assign dr_data_valid = in_data & gnt_q[1] & m_data_valid;
    assign ir_data       = (in_data && gnt_q[0]) ? m_data : '0;
    assign dr_data       = (in_data && gnt_q[1]) ? m_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_bus_read_arbiter.sv
// ============================================================================
// Module      : tb_bus_read_arbiter
// Description : Directed self-checking bench for bus_read_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_read_arbiter;

    localparam int c_W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
    logic [c_W-1:0] ir_addr, ir_data;
    logic           dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [c_W-1:0] dr_addr, dr_data;
    logic           m_addr_valid, m_addr_ready, m_data_valid, m_data_ready;
    logic [c_W-1:0] m_addr, m_data;
    logic [1:0]     gnt;

    int checks = 0;
    int errors = 0;

    bus_read_arbiter #(.BUS_WIDTH(c_W)) dut (
        .clk(clk), .rst(rst),
        .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
        .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
        .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
        .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
        .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready), .m_addr(m_addr),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data(m_data),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs;
        ir_addr_valid = 0; ir_addr = '0; ir_data_ready = 0;
        dr_addr_valid = 0; dr_addr = '0; dr_data_ready = 0;
        m_addr_ready  = 0; m_data_valid = 0; m_data = '0;
    endtask

    // Leaves the bench at a falling edge with reset released and DUT in IDLE.
    task automatic do_reset;
        clear_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 0;
        ir_addr_valid = 1; ir_addr = 32'h55; m_addr_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt); end
        checks++;
        if ({m_addr_valid, m_data_ready, ir_addr_ready, dr_addr_ready, ir_data_valid, dr_data_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_valids got %b exp 0",
                {m_addr_valid, m_data_ready, ir_addr_ready, dr_addr_ready, ir_data_valid, dr_data_valid});
        end
        checks++;
        if ({m_addr, ir_data, dr_data} !== '0) begin
            errors++; $display("FAIL reset_buses got %h exp 0", {m_addr, ir_data, dr_data});
        end
        clear_inputs();
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_single_ir;
        do_reset();
        ir_addr_valid = 1; ir_addr = 32'h100; m_addr_ready = 1; ir_data_ready = 1;
        #1;
        checks++; if (m_addr_valid !== 1'b0) begin errors++; $display("FAIL ir_idle_mvalid got %b exp 0", m_addr_valid); end
        @(negedge clk);
        m_data_valid = 1; m_data = 32'hDEADBEEF;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL ir_gnt got %b exp 01", gnt); end
        checks++; if ({m_addr_valid, m_addr} !== {1'b1, 32'h100}) begin
            errors++; $display("FAIL ir_maddr got %b/%h exp 1/00000100", m_addr_valid, m_addr); end
        checks++; if ({ir_addr_ready, ir_data_valid, m_data_ready} !== 3'b100) begin
            errors++; $display("FAIL ir_addr_phase got %b exp 100", {ir_addr_ready, ir_data_valid, m_data_ready}); end
        @(negedge clk);
        ir_addr_valid = 0;
        #1;
        checks++; if ({ir_data_valid, ir_data} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL ir_data got %b/%h exp 1/deadbeef", ir_data_valid, ir_data); end
        checks++; if ({dr_data_valid, dr_data, m_addr_valid, m_data_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ir_data_side got %b/%h/%b/%b exp 0/0/0/1", dr_data_valid, dr_data, m_addr_valid, m_data_ready); end
        @(negedge clk);
        #1;
        checks++; if ({gnt, ir_data_valid} !== 3'b000) begin
            errors++; $display("FAIL ir_done got %b/%b exp 00/0", gnt, ir_data_valid); end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_arbitration;
        logic [c_W-1:0] exp_seq [4];
        logic [c_W-1:0] got;
        int n = 0;
        int idle_after = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{32'h10, 32'h20, 32'h10, 32'h20};
`else
        exp_seq = '{32'h10, 32'h10, 32'h10, 32'h10};
`endif
        do_reset();
        ir_addr_valid = 1; ir_addr = 32'h10; dr_addr_valid = 1; dr_addr = 32'h20;
        m_addr_ready = 1; m_data_valid = 1; m_data = 32'h77; ir_data_ready = 1; dr_data_ready = 1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            #1;
            if (m_addr_valid && m_addr_ready) begin
                got = m_addr;
                checks++;
                if (got !== exp_seq[n]) begin
                    errors++; $display("FAIL arb_seq%0d got %h exp %h", n, got, exp_seq[n]);
                end
                n++;
            end
            if (m_data_ready && m_data_valid) idle_after++;
            @(negedge clk);
        end
        checks++; if (n != 4) begin errors++; $display("FAIL arb_timeout got %0d exp 4 transactions", n); end
        // The cycle after the last DATA handshake must be IDLE with no grant.
        @(negedge clk);
        #1;
        checks++; if ({gnt, m_addr_valid} !== 3'b000) begin
            errors++; $display("FAIL arb_spacing got %b/%b exp 00/0", gnt, m_addr_valid); end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_addr_and_data_stall;
        int hs = 0;
        do_reset();
        dr_addr_valid = 1; dr_addr = 32'h44; m_addr_ready = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (m_addr_valid && m_addr_ready) hs++;
            checks++;
            if ({gnt, m_addr_valid, m_addr, dr_addr_ready} !== {2'b10, 1'b1, 32'h44, 1'b0}) begin
                errors++; $display("FAIL stall_addr%0d got %b/%b/%h/%b exp 10/1/00000044/0",
                    i, gnt, m_addr_valid, m_addr, dr_addr_ready);
            end
            @(negedge clk);
        end
        m_addr_ready = 1;
        #1;
        if (m_addr_valid && m_addr_ready) hs++;
        @(negedge clk);
        dr_addr_valid = 0;
        #1;
        if (m_addr_valid && m_addr_ready) hs++;
        checks++; if (hs != 1) begin errors++; $display("FAIL stall_handshakes got %0d exp 1", hs); end
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL stall_data_gnt got %b exp 10", gnt); end
        m_data_valid = 1; m_data = 32'hCAFE0001; dr_data_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({m_data_ready, dr_data_valid, gnt} !== {1'b0, 1'b1, 2'b10}) begin
                errors++; $display("FAIL dstall%0d got %b/%b/%b exp 0/1/10", i, m_data_ready, dr_data_valid, gnt);
            end
            @(negedge clk);
        end
        dr_data_ready = 1;
        #1;
        checks++; if ({m_data_ready, dr_data, ir_data_valid} !== {1'b1, 32'hCAFE0001, 1'b0}) begin
            errors++; $display("FAIL dstall_release got %b/%h/%b exp 1/cafe0001/0", m_data_ready, dr_data, ir_data_valid); end
        @(negedge clk);
        #1;
        checks++; if ({gnt, m_data_ready} !== 3'b000) begin
            errors++; $display("FAIL dstall_done got %b/%b exp 00/0", gnt, m_data_ready); end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        do_reset();
        ir_addr_valid = 1; ir_addr = 32'h200; m_addr_ready = 1;
        repeat (2) @(negedge clk);
        ir_addr_valid = 0; m_data_valid = 1; m_data = 32'h12345678; ir_data_ready = 1;
        #1;
        checks++; if ({gnt, ir_data_valid} !== 3'b011) begin
            errors++; $display("FAIL rmid_pre got %b/%b exp 01/1", gnt, ir_data_valid); end
        rst = 0;
        #1;
        checks++;
        if ({gnt, ir_data_valid, m_data_ready, m_addr_valid, ir_data} !== {2'b00, 3'b000, 32'h0}) begin
            errors++; $display("FAIL rmid_async got %b/%b/%b/%b/%h exp 00/0/0/0/0",
                gnt, ir_data_valid, m_data_ready, m_addr_valid, ir_data);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({gnt, m_addr_valid} !== 3'b000) begin
            errors++; $display("FAIL rmid_after got %b/%b exp 00/0", gnt, m_addr_valid); end
        @(negedge clk);
    endtask

    task automatic test_addr_drop;
        int hs = 0;
        do_reset();
        dr_addr_valid = 1; dr_addr = 32'h400; m_addr_ready = 0;
        @(negedge clk);
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL drop_gnt got %b exp 10", gnt); end
        dr_addr_valid = 0; ir_addr_valid = 1; ir_addr = 32'h300; m_addr_ready = 1;
        #1;
        if (m_addr_valid && m_addr_ready) hs++;
        @(negedge clk);
        #1;
        if (m_addr_valid && m_addr_ready) hs++;
        checks++; if (hs != 0) begin errors++; $display("FAIL drop_handshake got %0d exp 0", hs); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL drop_idle got %b exp 00", gnt); end
        @(negedge clk);
        #1;
        checks++; if ({gnt, m_addr_valid, m_addr} !== {2'b01, 1'b1, 32'h300}) begin
            errors++; $display("FAIL drop_next got %b/%b/%h exp 01/1/00000300", gnt, m_addr_valid, m_addr); end
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        test_reset();
        test_single_ir();
        test_arbitration();
        test_addr_and_data_stall();
        test_reset_mid();
        test_addr_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
